// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared constants for the calculator sequencer: token class
//                codes, operator/command codes, error codes, FSM state
//                encoding and the default operand width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int c_DEFAULT_W = 10;

    // Token validity classes
    localparam logic [1:0] c_CLASS_INVALID  = 2'b00;
    localparam logic [1:0] c_CLASS_NUMBER   = 2'b01;
    localparam logic [1:0] c_CLASS_OPERATOR = 2'b10;
    localparam logic [1:0] c_CLASS_COMMAND  = 2'b11;

    // Operator codes (class operator)
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_DIV = 3'b011;

    // Command codes (class command)
    localparam logic [2:0] c_CMD_EQUALS = 3'b000;
    localparam logic [2:0] c_CMD_CLEAR  = 3'b001;

    // Error codes
    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_SYNTAX  = 2'b01;
    localparam logic [1:0] c_ERR_DIV0    = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b11;

    // Sequencer states
    localparam logic [3:0] c_S_IDLE       = 4'd0;
    localparam logic [3:0] c_S_HAVE_A     = 4'd1;
    localparam logic [3:0] c_S_HAVE_OP    = 4'd2;
    localparam logic [3:0] c_S_HAVE_B     = 4'd3;
    localparam logic [3:0] c_S_EXEC       = 4'd4;
    localparam logic [3:0] c_S_WAIT_ALU   = 4'd5;
    localparam logic [3:0] c_S_PRINT      = 4'd6;
    localparam logic [3:0] c_S_WAIT_PRINT = 4'd7;
    localparam logic [3:0] c_S_ERROR      = 4'd8;

    // True for the four defined arithmetic operator codes
    function automatic logic isOperatorCode(input logic [2:0] mode);
        return (mode <= c_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer_if
//  Description : Bundle of the sequencer's token, ALU, print and status
//                signals.
//  Ports       : master - sequencer side (consumes tokens, drives ALU/print)
//                slave  - environment side (interpreter, ALU, print path)
//  Revision    : 1.0 - initial release
// ============================================================================
interface calc_sequencer_if #(parameter int W = calc_pkg::c_DEFAULT_W);

    logic             tok_valid;
    logic [1:0]       tok_class;
    logic [W-1:0]     tok_num;
    logic [2:0]       tok_mode;

    logic             alu_start;
    logic [2:0]       alu_op;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic             alu_done;
    logic [2*W-1:0]   alu_result;

    logic             print_start;
    logic [2*W-1:0]   print_value;
    logic             print_busy;

    logic             err;
    logic [1:0]       err_code;
    logic             busy;

    modport master (
        input  tok_valid, tok_class, tok_num, tok_mode,
        input  alu_done, alu_result, print_busy,
        output alu_start, alu_op, alu_a, alu_b,
        output print_start, print_value, err, err_code, busy
    );

    modport slave (
        output tok_valid, tok_class, tok_num, tok_mode,
        output alu_done, alu_result, print_busy,
        input  alu_start, alu_op, alu_a, alu_b,
        input  print_start, print_value, err, err_code, busy
    );

endinterface
`default_nettype wire

// File: rtl/calc_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : calc_timeout_ctr
//  Description : Load/enable counter that flags expiry once it has counted
//                TIMEOUT-1 enabled cycles since the last load. Saturates at
//                the limit so the expiry flag stays asserted.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                i_load      - restart the count from zero
//                i_en        - count this cycle
//                o_expired   - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_en,
    output logic      o_expired
);

    localparam int                c_CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0]   c_LIMIT = c_CW'(TIMEOUT - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign o_expired = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer
//  Description : Calculator control FSM. Collects operand A, operator and
//                operand B from decoded tokens, launches the ALU on '=',
//                hands the result to the print path and chains small results
//                back in as the next operand A. Detects token-order errors,
//                divide-by-zero and ALU timeout.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - calc_sequencer_if.master (tokens in, ALU
//                           handshake, print handshake, err/err_code/busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W       = c_DEFAULT_W,
    parameter int TIMEOUT = 64
) (
    input  wire logic          clk,
    input  wire logic          rst,
    calc_sequencer_if.master   bus
);

    logic [3:0]       r_state;
    logic [W-1:0]     r_opA;
    logic [W-1:0]     r_opB;
    logic [2:0]       r_opCode;
    logic [2*W-1:0]   r_printValue;
    logic             r_err;
    logic [1:0]       r_errCode;
    logic             r_firstWait;

    logic w_isNumber;
    logic w_isOperator;
    logic w_isEquals;
    logic w_isClear;
    logic w_ctrLoad;
    logic w_ctrEn;
    logic w_ctrExpired;
    logic w_upperZero;

    // Token decode; reserved codes fall through to the syntax-error path
    assign w_isNumber   = bus.tok_valid && (bus.tok_class == c_CLASS_NUMBER);
    assign w_isOperator = bus.tok_valid && (bus.tok_class == c_CLASS_OPERATOR)
                          && isOperatorCode(bus.tok_mode);
    assign w_isEquals   = bus.tok_valid && (bus.tok_class == c_CLASS_COMMAND)
                          && (bus.tok_mode == c_CMD_EQUALS);
    assign w_isClear    = bus.tok_valid && (bus.tok_class == c_CLASS_COMMAND)
                          && (bus.tok_mode == c_CMD_CLEAR);

    // Counter is zeroed on the edge entering EXEC and counts through EXEC, so
    // expiry lands exactly TIMEOUT cycles after the alu_start cycle.
    assign w_ctrLoad   = (r_state == c_S_HAVE_B) && w_isEquals;
    assign w_ctrEn     = (r_state == c_S_EXEC) || (r_state == c_S_WAIT_ALU);
    assign w_upperZero = (r_printValue[2*W-1:W] == '0);

    calc_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeoutCtr (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_ctrLoad),
        .i_en      (w_ctrEn),
        .o_expired (w_ctrExpired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_opA        <= '0;
            r_opB        <= '0;
            r_opCode     <= '0;
            r_printValue <= '0;
            r_err        <= 1'b0;
            r_errCode    <= c_ERR_NONE;
            r_firstWait  <= 1'b0;
        end else if (w_isClear) begin
            // Clear wins in every state; an outstanding ALU result is dropped
            r_state     <= c_S_IDLE;
            r_opA       <= '0;
            r_opB       <= '0;
            r_opCode    <= '0;
            r_err       <= 1'b0;
            r_errCode   <= c_ERR_NONE;
            r_firstWait <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_isNumber) begin
                        r_opA   <= bus.tok_num;
                        r_state <= c_S_HAVE_A;
                    end else if (bus.tok_valid) begin
                        r_state   <= c_S_ERROR;
                        r_err     <= 1'b1;
                        r_errCode <= c_ERR_SYNTAX;
                    end
                end
                c_S_HAVE_A: begin
                    if (w_isNumber) begin
                        r_opA <= bus.tok_num;
                    end else if (w_isOperator) begin
                        r_opCode <= bus.tok_mode;
                        r_state  <= c_S_HAVE_OP;
                    end else if (w_isEquals) begin
                        r_printValue <= {{W{1'b0}}, r_opA};
                        r_state      <= c_S_PRINT;
                    end else if (bus.tok_valid) begin
                        r_state   <= c_S_ERROR;
                        r_err     <= 1'b1;
                        r_errCode <= c_ERR_SYNTAX;
                    end
                end
                c_S_HAVE_OP: begin
                    if (w_isNumber) begin
                        r_opB   <= bus.tok_num;
                        r_state <= c_S_HAVE_B;
                    end else if (w_isOperator) begin
                        r_opCode <= bus.tok_mode;
                    end else if (bus.tok_valid) begin
                        r_state   <= c_S_ERROR;
                        r_err     <= 1'b1;
                        r_errCode <= c_ERR_SYNTAX;
                    end
                end
                c_S_HAVE_B: begin
                    if (w_isNumber) begin
                        r_opB <= bus.tok_num;
                    end else if (w_isEquals) begin
                        if ((r_opCode == c_OP_DIV) && (r_opB == '0)) begin
                            r_state   <= c_S_ERROR;
                            r_err     <= 1'b1;
                            r_errCode <= c_ERR_DIV0;
                        end else begin
                            r_state <= c_S_EXEC;
                        end
                    end else if (bus.tok_valid) begin
                        r_state   <= c_S_ERROR;
                        r_err     <= 1'b1;
                        r_errCode <= c_ERR_SYNTAX;
                    end
                end
                c_S_EXEC: begin
                    r_state <= c_S_WAIT_ALU;
                end
                c_S_WAIT_ALU: begin
                    // done is tested first so it wins a tie with expiry
                    if (bus.alu_done) begin
                        r_printValue <= bus.alu_result;
                        r_state      <= c_S_PRINT;
                    end else if (w_ctrExpired) begin
                        r_state   <= c_S_ERROR;
                        r_err     <= 1'b1;
                        r_errCode <= c_ERR_TIMEOUT;
                    end
                end
                c_S_PRINT: begin
                    r_state     <= c_S_WAIT_PRINT;
                    r_firstWait <= 1'b1;
                end
                c_S_WAIT_PRINT: begin
                    // The print path may not raise busy until a cycle after
                    // print_start, so the first cycle here ignores busy.
                    if (r_firstWait) begin
                        r_firstWait <= 1'b0;
                    end else if (!bus.print_busy) begin
                        if (w_upperZero) begin
                            r_opA   <= r_printValue[W-1:0];
                            r_state <= c_S_HAVE_A;
                        end else begin
                            r_state <= c_S_IDLE;
                        end
                    end
                end
                c_S_ERROR: begin
                    r_state <= c_S_ERROR;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_start   = (r_state == c_S_EXEC);
    assign bus.alu_op      = r_opCode;
    assign bus.alu_a       = r_opA;
    assign bus.alu_b       = r_opB;
    assign bus.print_start = (r_state == c_S_PRINT);
    assign bus.print_value = r_printValue;
    assign bus.err         = r_err;
    assign bus.err_code    = r_errCode;
    assign bus.busy        = (r_state == c_S_EXEC) || (r_state == c_S_WAIT_ALU) ||
                             (r_state == c_S_PRINT) || (r_state == c_S_WAIT_PRINT);

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Central controller of the calculator.
- Consumes decoded tokens from the ASCII data interpreter: operand value, mode/operator code, validity class and strobe.
- Sequences operand A -> operator -> operand B -> '=' into the shared arithmetic unit, then hands the result to the print path.
- Owns error detection (bad token order, divide-by-zero, ALU timeout) and result chaining.

Parameters:
- W, 10, operand width; matches the interpreter number output.
- TIMEOUT, 64, maximum cycles to wait for alu_done before declaring an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tok_valid  in  1  one-cycle strobe; a token is present this cycle.
- tok_class  in  2  00 invalid, 01 number, 10 operator, 11 command.
- tok_num  in  W  operand value; used when tok_class=01.
- tok_mode  in  3  operator: 000 add, 001 sub, 010 mul, 011 div. Command: 000 '=', 001 clear. Other codes are invalid.
- alu_start  out  1  one-cycle pulse; launches an operation.
- alu_op  out  3  latched operator.
- alu_a  out  W  latched operand A.
- alu_b  out  W  latched operand B.
- alu_done  in  1  one-cycle result-ready strobe.
- alu_result  in  2W  full-width result.
- print_start  out  1  one-cycle pulse to the display/print path.
- print_value  out  2W  value to print; held stable until print_busy falls.
- print_busy  in  1  high while the print path is busy.
- err  out  1  sticky error flag.
- err_code  out  2  01 syntax, 10 divide-by-zero, 11 timeout.
- busy  out  1  high in EXEC and PRINT.

Behaviour:
- Clocking and reset:
  - All logic runs on posedge clk.
  - While rst=1: state=IDLE; all outputs 0; A, B, op and timeout counter cleared.
  - rst has priority over every other event, including mid-EXEC and mid-PRINT.
- FSM states: IDLE, HAVE_A, HAVE_OP, HAVE_B, EXEC, WAIT_ALU, PRINT, WAIT_PRINT, ERROR.
- Token handling applies only when tok_valid=1.
- Clear command (class 11, mode 001):
  - From any state: next state IDLE; A, B, op, err and err_code cleared.
  - A clear in WAIT_ALU abandons the operation; a later alu_done is ignored.
- Transitions on valid tokens:
  - IDLE + number: A := tok_num, go HAVE_A.
  - HAVE_A + number: overwrite A.
  - HAVE_A + valid operator: op latched, go HAVE_OP.
  - HAVE_A + '=': print_value := zero-extended A, go PRINT.
  - HAVE_OP + operator: overwrite op.
  - HAVE_OP + number: B latched, go HAVE_B.
  - HAVE_B + number: overwrite B.
  - HAVE_B + '=':
    - If op=div and B=0: err_code=10, go ERROR. No alu_start is issued.
    - Otherwise go EXEC.
  - Any other token in IDLE..HAVE_B (class 00, reserved mode, '=' in IDLE or HAVE_OP, operator in IDLE or HAVE_B): err_code=01, go ERROR.
- EXEC:
  - alu_start=1 for exactly one cycle; next state WAIT_ALU.
  - Timeout counter reset to 0 on entry.
- WAIT_ALU:
  - Counter increments each cycle.
  - alu_done=1: print_value := alu_result, go PRINT.
  - Counter reaches TIMEOUT-1 without done: err_code=11, go ERROR.
  - If done and the timeout limit coincide in the same cycle, done wins.
- PRINT:
  - print_start=1 for one cycle; go WAIT_PRINT.
- WAIT_PRINT:
  - Stays while print_busy=1, and also for the first cycle after PRINT regardless of busy.
  - When busy falls:
    - If result[2W-1:W]==0: A := result[W-1:0], go HAVE_A (chaining).
    - Otherwise go IDLE.
- Tokens during EXEC..WAIT_PRINT other than clear are dropped silently. No error is raised.
- ERROR:
  - err=1, held until clear or rst.
  - All non-clear tokens are ignored.
- Latency:
  - '=' token to alu_start: 1 cycle.
  - alu_done to print_start: 1 cycle.
- Stability: alu_a, alu_b and alu_op are stable from the alu_start cycle until leaving WAIT_ALU.

Decomposition:
- Shared package calc_pkg holds:
  - Token class constants.
  - Operator and command codes.
  - err_code values.
  - State enum.
  - Default W.
- One natural sub-module: calc_timeout_ctr, a load/enable/expire counter parameterized by TIMEOUT. Everything else stays in one FSM module.

Test Plan:
- Tokens num 3, op add, num 6, '=' with ALU done after 4 cycles, result 9 -> exactly one alu_start with a=3, b=6, op=000; one print_start with print_value=9; state HAVE_A with A=9.
- num 12, op div, num 0, '=' -> no alu_start; err=1, err_code=10; following num 5 ignored; clear -> err=0, state IDLE.
- num 20, op mul, num 50, '=' with ALU never done -> err_code=11 exactly TIMEOUT cycles after alu_start; no print_start.
- Operator token in IDLE, and separately class-00 token in HAVE_A -> err_code=01; err stays 1 until clear.
- num 1000, op mul, num 1000, '=' with result 1000000 -> print_value=1000000; after busy falls, state IDLE (no chaining).
- rst asserted in WAIT_ALU, then alu_done pulse -> no print_start; all outputs 0; state IDLE. Also: clear during WAIT_PRINT -> state IDLE the next cycle.
